// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares the single-port data RAM between the CPU data-memory port and the
// VGA sprite/score fetch path. The CPU always owns the port when it asks for
// it and sees no added latency. VGA reads are parked in a one-entry buffer
// and slotted into cycles where the CPU leaves the port idle.
module dmem_port_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 64
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              cpu_wren,
    input  logic              cpu_rden,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    output logic [DATA_W-1:0] cpu_q,

    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_valid,
    output logic [DATA_W-1:0] vga_q,
    output logic              vga_starve,

    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    // Counter must be able to hold STARVE_LIMIT itself, where it saturates.
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(STARVE_LIMIT);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] pend_addr;
    logic              svc_d1;
    logic [CNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]  wait_inc;
    logic              starve_q;

    logic cpu_access;
    logic vga_accept;
    logic vga_service;
    logic vga_blocked;

    // A simultaneous write and read strobe is handled as a write, so only
    // the OR of the two decides port ownership.
    assign cpu_access  = cpu_wren | cpu_rden;
    assign vga_gnt     = (state == ST_IDLE);
    assign vga_accept  = vga_req & vga_gnt;
    assign vga_service = (state == ST_PEND) & ~cpu_access;
    assign vga_blocked = (state == ST_PEND) & cpu_access;
    assign wait_inc    = wait_cnt + CNT_W'(1);

    // Both readers see the raw RAM output; each qualifies it with its own timing.
    assign cpu_q      = ram_dout;
    assign vga_q      = ram_dout;
    assign vga_valid  = svc_d1;
    assign vga_starve = starve_q;

    // RAM port steering: CPU first, then the parked VGA read, else park at zero.
    always_comb begin
        ram_wen  = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (cpu_access) begin
            ram_wen  = cpu_wren;
            ram_addr = cpu_addr;
            ram_din  = cpu_data;
        end else if (vga_service) begin
            ram_addr = pend_addr;
        end
    end

    // Pending-buffer control: capture on accept, release on service.
    // Accept only happens from IDLE and service only from PEND, so a request
    // can never be accepted and serviced in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            pend_addr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (vga_accept) begin
                        state     <= ST_PEND;
                        pend_addr <= vga_addr;
                    end
                end
                ST_PEND: begin
                    if (vga_service) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read-return flag: the RAM answers one cycle after a service cycle.
    // Reset clears it so an in-flight read never produces a valid pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            svc_d1 <= 1'b0;
        end else begin
            svc_d1 <= vga_service;
        end
    end

    // Starvation tracking: count consecutive CPU-blocked cycles while a VGA
    // read is parked; the flag latches when the count first hits the limit
    // and only reset clears it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            starve_q <= 1'b0;
        end else begin
            if (vga_service) begin
                wait_cnt <= '0;
            end else if (vga_blocked && (wait_cnt != WAIT_MAX)) begin
                wait_cnt <= wait_inc;
                if (wait_inc == WAIT_MAX) begin
                    starve_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter
// Directed bench for the data-RAM arbiter with a synchronous RAM model, a
// queue-based reference model compared every cycle, and literal spot checks.
module tb_dmem_port_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int LIMIT  = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              cpu_wren, cpu_rden;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_data;
    logic [DATA_W-1:0] cpu_q;
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_gnt, vga_valid, vga_starve;
    logic [DATA_W-1:0] vga_q;
    logic              ram_wen;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    dmem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clock(clock), .reset(reset),
        .cpu_wren(cpu_wren), .cpu_rden(cpu_rden), .cpu_addr(cpu_addr),
        .cpu_data(cpu_data), .cpu_q(cpu_q),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
        .vga_valid(vga_valid), .vga_q(vga_q), .vga_starve(vga_starve),
        .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    always #5 clock = ~clock;

    // Synchronous single-port RAM, read-old-data; preloaded on the first edge.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    bit mem_ready;
    always @(posedge clock) begin
        if (!mem_ready) begin
            for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
            mem[12'h2A0] <= 32'h0000_00FF;
            mem_ready <= 1'b1;
        end else if (ram_wen) begin
            mem[ram_addr] <= ram_din;
        end
        ram_dout <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a queue of parked VGA addresses, a run length of
    // blocked cycles, and the read results owed on the next cycle.
    logic [ADDR_W-1:0] m_pend [$];
    int                m_run;
    bit                m_starve;
    bit                m_vvalid;
    logic [DATA_W-1:0] m_vdata;
    bit                m_cvalid;
    logic [DATA_W-1:0] m_cdata;
    int                log_cyc [$];
    logic [DATA_W-1:0] log_dat [$];

    always @(negedge clock) begin
        bit                had_pend;
        bit                cpu_acc;
        logic              e_wen;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_din;
        cyc++;
        if (reset) begin
            m_pend.delete();
            m_run = 0; m_starve = 0; m_vvalid = 0; m_cvalid = 0;
        end
        had_pend = (m_pend.size() != 0);
        cpu_acc  = cpu_wren | cpu_rden;
        e_wen = 1'b0; e_addr = '0; e_din = '0;
        if (cpu_acc) begin
            e_wen = cpu_wren; e_addr = cpu_addr; e_din = cpu_data;
        end else if (had_pend) begin
            e_addr = m_pend[0];
        end
        check("gnt", 32'(vga_gnt), 32'(!had_pend));
        check("ram_wen", 32'(ram_wen), 32'(e_wen));
        check("ram_addr", 32'(ram_addr), 32'(e_addr));
        check("ram_din", ram_din, e_din);
        check("vga_valid", 32'(vga_valid), 32'(m_vvalid));
        check("vga_starve", 32'(vga_starve), 32'(m_starve));
        if (m_vvalid) check("vga_q", vga_q, m_vdata);
        if (m_cvalid) check("cpu_q", cpu_q, m_cdata);
        if (vga_valid) begin
            log_cyc.push_back(cyc);
            log_dat.push_back(vga_q);
        end
        if (!reset) begin
            m_cvalid = cpu_rden && !cpu_wren;
            if (m_cvalid) m_cdata = mem[cpu_addr];
            m_vvalid = 1'b0;
            if (had_pend && !cpu_acc) begin
                m_vvalid = 1'b1;
                m_vdata  = mem[m_pend[0]];
                void'(m_pend.pop_front());
                m_run = 0;
            end else if (had_pend) begin
                if (m_run < LIMIT) m_run++;
                if (m_run == LIMIT) m_starve = 1'b1;
            end
            if (!had_pend && vga_req) m_pend.push_back(vga_addr);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_stimulus(input logic wr, input logic rd,
                                  input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        cpu_wren = wr; cpu_rden = rd; cpu_addr = a; cpu_data = d;
    endtask

    task automatic wait_gnt(input int budget);
        int n = 0;
        while (!vga_gnt && n < budget) begin
            step();
            n++;
        end
        check("wait_gnt", 32'(vga_gnt), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        vga_req = 1'b0; vga_addr = '0;
        apply_stimulus(1'b0, 1'b0, '0, '0);
        step(); step();
        reset = 1'b0;
        #1;
        check("lit_reset_gnt", 32'(vga_gnt), 32'd1);
        check("lit_reset_valid", 32'(vga_valid), 32'd0);
        check("lit_reset_starve", 32'(vga_starve), 32'd0);
        check("lit_reset_port", 32'(ram_addr) | 32'(ram_wen) | ram_din, 32'd0);

        // Reset while a request for 0x123 is parked behind the CPU.
        vga_req = 1'b1; vga_addr = 12'h123;
        step();
        vga_req = 1'b0;
        apply_stimulus(1'b0, 1'b1, 12'h321, 32'h0);
        #1;
        check("lit_pend_gnt", 32'(vga_gnt), 32'd0);
        reset = 1'b1;
        #1;
        check("lit_rst_mid_gnt", 32'(vga_gnt), 32'd1);
        check("lit_rst_mid_starve", 32'(vga_starve), 32'd0);
        check("lit_rst_mid_addr", 32'(ram_addr), 32'h321);
        step(); step();
        reset = 1'b0;
        apply_stimulus(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("lit_dropped_valid", 32'(vga_valid), 32'd0);
            check("lit_dropped_addr", 32'(ram_addr), 32'd0);
            step();
        end

        // CPU pass-through write, then read back.
        apply_stimulus(1'b1, 1'b0, 12'h010, 32'hDEAD_BEEF);
        #1;
        check("lit_wr_wen", 32'(ram_wen), 32'd1);
        check("lit_wr_addr", 32'(ram_addr), 32'h010);
        check("lit_wr_din", ram_din, 32'hDEAD_BEEF);
        step();
        apply_stimulus(1'b0, 1'b1, 12'h010, 32'h0);
        step();
        apply_stimulus(1'b0, 1'b0, '0, '0);
        #1;
        check("lit_rd_q", cpu_q, 32'hDEAD_BEEF);

        // Lone VGA read with the CPU idle.
        wait_gnt(10);
        vga_req = 1'b1; vga_addr = 12'h2A0;
        step();
        vga_req = 1'b0;
        #1;
        check("lit_lone_addr", 32'(ram_addr), 32'h2A0);
        check("lit_lone_wen", 32'(ram_wen), 32'd0);
        check("lit_lone_novalid", 32'(vga_valid), 32'd0);
        step();
        #1;
        check("lit_lone_valid", 32'(vga_valid), 32'd1);
        check("lit_lone_q", vga_q, 32'h0000_00FF);
        step();
        #1;
        check("lit_lone_valid_off", 32'(vga_valid), 32'd0);

        // Streaming: eight reads issued whenever the grant is up.
        log_cyc.delete(); log_dat.delete();
        for (int i = 0; i < 8; i++) begin
            wait_gnt(10);
            vga_req = 1'b1; vga_addr = 12'h100 + 12'(i);
            step();
            vga_req = 1'b0;
        end
        repeat (4) step();
        check("lit_stream_count", 32'(log_cyc.size()), 32'd8);
        for (int i = 0; i < 8 && i < log_dat.size(); i++) begin
            check("lit_stream_data", log_dat[i], 32'hC0DE_0100 + 32'(i));
            if (i > 0) check("lit_stream_gap", 32'(log_cyc[i] - log_cyc[i-1]), 32'd2);
        end

        // Contention: five CPU loads while a VGA read is parked.
        wait_gnt(10);
        vga_req = 1'b1; vga_addr = 12'h055;
        step();
        vga_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b0, 1'b1, 12'h200 + 12'(i), 32'h0);
            #1;
            check("lit_cont_addr", 32'(ram_addr), 32'h200 + 32'(i));
            check("lit_cont_novalid", 32'(vga_valid), 32'd0);
            if (i > 0) check("lit_cont_cpu_q", cpu_q, 32'hC0DE_0200 + 32'(i - 1));
            step();
        end
        apply_stimulus(1'b0, 1'b0, '0, '0);
        #1;
        check("lit_cont_svc_addr", 32'(ram_addr), 32'h055);
        check("lit_cont_last_q", cpu_q, 32'hC0DE_0204);
        step();
        #1;
        check("lit_cont_valid", 32'(vga_valid), 32'd1);
        check("lit_cont_vq", vga_q, 32'hC0DE_0055);

        // Starvation: six blocked cycles against a limit of four.
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("lit_starve_clear", 32'(vga_starve), 32'd0);
        wait_gnt(10);
        vga_req = 1'b1; vga_addr = 12'h077;
        step();
        vga_req = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            apply_stimulus(1'b0, 1'b1, 12'h300, 32'h0);
            step();
            #1;
            check("lit_starve_ramp", 32'(vga_starve), (i >= LIMIT) ? 32'd1 : 32'd0);
        end
        apply_stimulus(1'b0, 1'b0, '0, '0);
        #1;
        check("lit_starve_svc_addr", 32'(ram_addr), 32'h077);
        step();
        #1;
        check("lit_starve_valid", 32'(vga_valid), 32'd1);
        check("lit_starve_sticky", 32'(vga_starve), 32'd1);
        step(); step();
        check("lit_starve_still", 32'(vga_starve), 32'd1);
        reset = 1'b1;
        #1;
        check("lit_starve_reset", 32'(vga_starve), 32'd0);
        step();
        reset = 1'b0;
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares the single-port data RAM between the processor's data-memory port and the VGA controller's sprite/score fetch path. The processor always has absolute priority and sees zero added latency. The VGA side gets a request/grant handshake with a one-entry pending buffer that is serviced in idle processor cycles. The block sits between the CPU/VGA controller and the RAM instance in the top-level wrapper.

## Interface
- ADDR_W, 12, RAM word-address width (CPU uses memAddr[11:0])
- DATA_W, 32, RAM data width
- STARVE_LIMIT, 64, consecutive blocked cycles before the starvation flag sets
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_wren  in  1  CPU store this cycle
- cpu_rden  in  1  CPU load this cycle
- cpu_addr  in  ADDR_W  CPU word address
- cpu_data  in  DATA_W  CPU store data
- cpu_q  out  DATA_W  CPU load data (= ram_dout)
- vga_req  in  1  VGA read request, qualified by vga_gnt
- vga_addr  in  ADDR_W  VGA read address, sampled on accept
- vga_gnt  out  1  arbiter can accept a VGA request this cycle
- vga_valid  out  1  vga_q holds the returned word this cycle
- vga_q  out  DATA_W  VGA read data (= ram_dout)
- vga_starve  out  1  sticky: VGA was blocked STARVE_LIMIT consecutive cycles
- ram_wen  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_din  out  DATA_W  RAM write data
- ram_dout  in  DATA_W  RAM read data, valid one cycle after the address

## Operation
- **States**
  - IDLE: no VGA request held.
  - PEND: one VGA address held in pend_addr.
- **Accept**
  - vga_gnt = (state == IDLE).
  - vga_req && vga_gnt at a rising edge latches vga_addr into pend_addr; state becomes PEND.
- **CPU access** (cpu_wren | cpu_rden)
  - The RAM port is driven combinationally from the CPU: ram_addr=cpu_addr, ram_din=cpu_data, ram_wen=cpu_wren.
  - Both cpu_wren and cpu_rden high is treated as a write.
  - The CPU is never stalled or delayed.
- **VGA service**
  - Occurs when state==PEND and there is no CPU access.
  - ram_addr=pend_addr, ram_wen=0, ram_din=0.
  - At the edge, state returns to IDLE and svc_d1 is set.
- **Idle port**
  - With neither a CPU access nor a VGA service, ram_addr=0, ram_wen=0, ram_din=0.
- **Read return**
  - vga_valid = svc_d1 (registered; high exactly one cycle).
  - vga_q and cpu_q are both wired to ram_dout. Consumers qualify with their own valid or timing.
- **Starvation**
  - wait_cnt (width clog2(STARVE_LIMIT+1)) increments each cycle in PEND with a CPU access present, saturating at STARVE_LIMIT.
  - wait_cnt clears on VGA service.
  - wait_cnt reaching STARVE_LIMIT sets vga_starve, which stays set until reset.
- **Reset** (async, mid-operation allowed)
  - state=IDLE, pend_addr=0, svc_d1=0, wait_cnt=0, vga_starve=0.
  - A pending or in-flight VGA read is dropped; no vga_valid is produced for it.

## Timing
- **Reset values:** vga_gnt=1, vga_valid=0, vga_starve=0. ram_wen, ram_addr and ram_din are 0 when CPU inputs are 0.
- **CPU path:** fully combinational to the RAM port; CPU latency is unchanged (load data one cycle after address).
- **VGA latency:** request accepted at edge N → earliest service in cycle N+1 → vga_valid in cycle N+2. Each cycle of CPU activity during PEND adds one cycle.
- **Back-to-back VGA:** vga_gnt rises in the cycle after service. A new request accepted then overlaps the previous return, giving 1 word per 2 cycles at best.
- **vga_req while vga_gnt=0:** ignored. The requester must hold vga_req and vga_addr until it is accepted.
- **Same-cycle accept and service:** never occurs; a request is always serviced at the earliest in the cycle after it is accepted.

## Test plan
- **Reset:** assert reset mid-PEND with pend_addr=0x123 → vga_gnt=1, vga_valid never pulses for 0x123, vga_starve=0, and the RAM port is driven by the CPU inputs.
- **CPU pass-through:** cpu_wren=1, cpu_addr=0x010, cpu_data=0xDEADBEEF → ram_wen=1, ram_addr=0x010, ram_din=0xDEADBEEF in the same cycle. A later cpu_rden of 0x010 → cpu_q=0xDEADBEEF next cycle.
- **Lone VGA read:** RAM[0x2A0]=0x0000_00FF, CPU idle, vga_req accepted at edge N → ram_addr=0x2A0 in cycle N+1, vga_valid=1 with vga_q=0x0000_00FF in cycle N+2 only.
- **Contention:** CPU loads every cycle for 5 cycles while the VGA request is pending → VGA is serviced in the first CPU-idle cycle; vga_valid follows one cycle later; CPU accesses are unaffected.
- **Starvation:** STARVE_LIMIT=4, CPU busy for 6 cycles with a VGA request pending → vga_starve rises after 4 blocked cycles and stays 1 after the service completes, until reset.
- **Streaming:** 8 VGA reads of addresses 0x100–0x107 issued at each vga_gnt with the CPU idle → 8 vga_valid pulses 2 cycles apart with in-order data.
